// File: rtl/uidbuf_pkg.sv
// Shared FSM encoding and elaboration-time helpers for the uidbuf read path.
package uidbuf_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RST   = 2'd1,
    S_DATA1 = 2'd2,
    S_DATA2 = 2'd3
  } state_e;

  // Ceiling log2 for sizing counters and pointers from parameters.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/rdbuf_sfifo.sv
// Single-clock show-ahead FIFO: dout is the head entry whenever empty is low.
// Flush has priority over push and pop; push while full and pop while empty are ignored.
module rdbuf_sfifo
  import uidbuf_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = 512,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  // NOTE: the storage array has no reset; only the pointers and count define
  // which entries are valid, so resetting the RAM would buy nothing.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uidbuf_only_r.sv
// Read-only FDMA frame buffer controller: per frame sync, fetch XDIV strided bursts per
// line into a FIFO and stream them out. Optional RDBUF_UNDERFLOW_CNT_EN adds O_R_underflow.
module uidbuf_only_r
  import uidbuf_pkg::*;
#(
  parameter int VIDEO_ENABLE   = 1,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int R_BUFDEPTH     = 512,
  parameter logic [AXI_ADDR_WIDTH-1:0] R_BASEADDR = '0,
  parameter int R_DSIZEBITS    = 24,
  parameter int R_XSIZE        = 240,
  parameter int R_XSTRIDE      = 240,
  parameter int R_YSIZE        = 1080,
  parameter int R_XDIV         = 2,
  parameter int R_BUFSIZE      = 3,
  parameter int IRQ_CYCLES     = 60
) (
  input  logic                      I_ui_clk,
  input  logic                      I_ui_rstn,
  input  logic                      I_R_FS,
  output logic [7:0]                O_R_sync_cnt,
  input  logic [7:0]                I_R_buf,
  output logic [AXI_DATA_WIDTH-1:0] O_R_data,
  output logic                      O_R_valid,
  input  logic                      I_R_ready,
  output logic [AXI_ADDR_WIDTH-1:0] O_fdma_raddr,
  output logic                      O_fdma_rareq,
  output logic [15:0]               O_fdma_rsize,
  input  logic                      I_fdma_rbusy,
  input  logic [AXI_DATA_WIDTH-1:0] I_fdma_rdata,
  input  logic                      I_fdma_rvalid,
  output logic                      O_fdma_rready,
  output logic [7:0]                O_fmda_rbuf,
  output logic                      O_fdma_rirq
`ifdef RDBUF_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]               O_R_underflow
`endif
);

  localparam int FDMA_RX_BURST = R_XSIZE / R_XDIV;
  localparam int BURST_INC     = FDMA_RX_BURST * AXI_DATA_WIDTH / 8;
  localparam int LAST_INC      = (R_XSTRIDE - R_XSIZE) * AXI_DATA_WIDTH / 8 + BURST_INC;
  localparam int TOTAL         = R_YSIZE * R_XDIV;
  localparam int CNT_W         = clog2(R_BUFDEPTH) + 1;
  localparam int BCNT_W        = clog2(TOTAL + 1);
  localparam int DIV_W         = clog2(R_XDIV + 1);

  state_e                 state_q, state_d;
  logic                   rareq_q, rareq_d;
  logic [R_DSIZEBITS-1:0] r_addr_q, r_addr_d;
  logic [BCNT_W-1:0]      bcnt_q, bcnt_d;
  logic [DIV_W-1:0]       divcnt_q, divcnt_d;
  logic [4:0]             rst_cnt_q, rst_cnt_d;
  logic [7:0]             rbufn_q, rbufn_d;
  logic [7:0]             sync_cnt_q, sync_cnt_d;
  logic [7:0]             rbuf_out_q, rbuf_out_d;
  logic [5:0]             irq_cnt_q, irq_cnt_d;
  logic [1:0]             fs_q;
  logic                   fs_start;
  logic                   fifo_flush;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic [CNT_W-1:0]       fifo_count;
  logic [AXI_DATA_WIDTH-1:0] fifo_dout;
  logic                   free_ok;
  logic                   rst_done;

  // With VIDEO_ENABLE=0 frames run back to back, as if FS were held high.
  assign fs_start = (VIDEO_ENABLE != 0) ? (fs_q[0] && !fs_q[1]) : 1'b1;
  assign free_ok  = (fifo_count <= CNT_W'(R_BUFDEPTH - FDMA_RX_BURST));
  assign rst_done = (VIDEO_ENABLE != 0) ? (rst_cnt_q == 5'd31) : 1'b1;

  rdbuf_sfifo #(
    .WIDTH (AXI_DATA_WIDTH),
    .DEPTH (R_BUFDEPTH)
  ) u_fifo (
    .clk   (I_ui_clk),
    .rst_n (I_ui_rstn),
    .flush (fifo_flush),
    .push  (I_fdma_rvalid && !fifo_full),
    .din   (I_fdma_rdata),
    .pop   (I_R_ready),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // NOTE: every _d signal gets a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    rareq_d    = rareq_q;
    r_addr_d   = r_addr_q;
    bcnt_d     = bcnt_q;
    divcnt_d   = divcnt_q;
    rst_cnt_d  = rst_cnt_q;
    rbufn_d    = rbufn_q;
    sync_cnt_d = sync_cnt_q;
    rbuf_out_d = rbuf_out_q;
    irq_cnt_d  = (irq_cnt_q != '0) ? irq_cnt_q - 6'd1 : '0;
    fifo_flush = 1'b0;

    case (state_q)
      S_IDLE: begin
        r_addr_d  = '0;
        bcnt_d    = '0;
        divcnt_d  = '0;
        rst_cnt_d = '0;
        rareq_d   = 1'b0;
        if (fs_start) begin
          state_d    = S_RST;
          sync_cnt_d = (sync_cnt_q == 8'(R_BUFSIZE - 1)) ? '0 : sync_cnt_q + 8'd1;
        end
      end
      S_RST: begin
        rbufn_d    = I_R_buf;
        fifo_flush = (VIDEO_ENABLE != 0) && (rst_cnt_q < 5'd16);
        if (rst_cnt_q != 5'd31) rst_cnt_d = rst_cnt_q + 5'd1;
        if (rst_done && irq_cnt_q == '0) state_d = S_DATA1;
      end
      S_DATA1: begin
        if (!rareq_q) begin
          if (free_ok && !I_fdma_rbusy) rareq_d = 1'b1;
        end else if (I_fdma_rbusy) begin
          rareq_d = 1'b0;
          state_d = S_DATA2;
        end
      end
      S_DATA2: begin
        if (!I_fdma_rbusy) begin
          if (bcnt_q == BCNT_W'(TOTAL - 1)) begin
            state_d    = S_IDLE;
            rbuf_out_d = rbufn_q;
            irq_cnt_d  = 6'(IRQ_CYCLES);
          end else begin
            state_d = S_DATA1;
            bcnt_d  = bcnt_q + BCNT_W'(1);
            // The last burst of a line skips the stride gap to the next line start.
            if (divcnt_q < DIV_W'(R_XDIV - 1)) begin
              divcnt_d = divcnt_q + DIV_W'(1);
              r_addr_d = r_addr_q + R_DSIZEBITS'(BURST_INC);
            end else begin
              divcnt_d = '0;
              r_addr_d = r_addr_q + R_DSIZEBITS'(LAST_INC);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments make every register sample pre-edge values,
  // independent of the order the statements are written in.
  always_ff @(posedge I_ui_clk or negedge I_ui_rstn) begin
    if (!I_ui_rstn) begin
      state_q    <= S_IDLE;
      rareq_q    <= 1'b0;
      r_addr_q   <= '0;
      bcnt_q     <= '0;
      divcnt_q   <= '0;
      rst_cnt_q  <= '0;
      rbufn_q    <= '0;
      sync_cnt_q <= '0;
      rbuf_out_q <= '0;
      irq_cnt_q  <= '0;
      fs_q       <= '0;
    end else begin
      state_q    <= state_d;
      rareq_q    <= rareq_d;
      r_addr_q   <= r_addr_d;
      bcnt_q     <= bcnt_d;
      divcnt_q   <= divcnt_d;
      rst_cnt_q  <= rst_cnt_d;
      rbufn_q    <= rbufn_d;
      sync_cnt_q <= sync_cnt_d;
      rbuf_out_q <= rbuf_out_d;
      irq_cnt_q  <= irq_cnt_d;
      fs_q       <= {fs_q[0], I_R_FS};
    end
  end

`ifdef RDBUF_UNDERFLOW_CNT_EN
  logic [15:0] uf_q, uf_d;

  always_comb begin
    uf_d = uf_q;
    if (state_q == S_IDLE) begin
      if (fs_start) uf_d = '0;
    end else if (I_R_ready && fifo_empty && uf_q != 16'hFFFF) begin
      uf_d = uf_q + 16'd1;
    end
  end

  always_ff @(posedge I_ui_clk or negedge I_ui_rstn) begin
    if (!I_ui_rstn) uf_q <= '0;
    else            uf_q <= uf_d;
  end

  assign O_R_underflow = uf_q;
`endif

  assign O_R_sync_cnt  = sync_cnt_q;
  assign O_R_data      = fifo_empty ? '0 : fifo_dout;
  assign O_R_valid     = !fifo_empty;
  assign O_fdma_raddr  = R_BASEADDR + AXI_ADDR_WIDTH'({rbufn_q, r_addr_q});
  assign O_fdma_rareq  = rareq_q;
  assign O_fdma_rsize  = 16'(FDMA_RX_BURST);
  assign O_fdma_rready = 1'b1;
  assign O_fmda_rbuf   = rbuf_out_q;
  assign O_fdma_rirq   = (irq_cnt_q != '0);

endmodule

// File: tb/tb_uidbuf_only_r.sv
// Directed bench for uidbuf_only_r: frame table plus reset-abort and optional underflow sequences.
module tb_uidbuf_only_r;
  import uidbuf_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fs;
  logic [7:0]   sync_cnt;
  logic [7:0]   rbuf_sel;
  logic [127:0] r_data;
  logic         r_valid;
  logic         r_ready;
  logic [31:0]  raddr;
  logic         rareq;
  logic [15:0]  rsize;
  logic         rbusy;
  logic [127:0] rdata;
  logic         rvalid;
  logic         rready;
  logic [7:0]   done_buf;
  logic         rirq;
`ifdef RDBUF_UNDERFLOW_CNT_EN
  logic [15:0]  underflow;
`endif

  always #5 clk = ~clk;

  uidbuf_only_r #(
    .R_XSIZE    (8),
    .R_XDIV     (2),
    .R_YSIZE    (2),
    .R_XSTRIDE  (16),
    .R_BUFDEPTH (16),
    .R_BUFSIZE  (3),
    .IRQ_CYCLES (60)
  ) dut (
    .I_ui_clk      (clk),
    .I_ui_rstn     (rst_n),
    .I_R_FS        (fs),
    .O_R_sync_cnt  (sync_cnt),
    .I_R_buf       (rbuf_sel),
    .O_R_data      (r_data),
    .O_R_valid     (r_valid),
    .I_R_ready     (r_ready),
    .O_fdma_raddr  (raddr),
    .O_fdma_rareq  (rareq),
    .O_fdma_rsize  (rsize),
    .I_fdma_rbusy  (rbusy),
    .I_fdma_rdata  (rdata),
    .I_fdma_rvalid (rvalid),
    .O_fdma_rready (rready),
    .O_fmda_rbuf   (done_buf),
    .O_fdma_rirq   (rirq)
`ifdef RDBUF_UNDERFLOW_CNT_EN
    ,
    .O_R_underflow (underflow)
`endif
  );

  typedef struct {
    logic [7:0]       buf_sel;
    logic             ready;
    logic             mid_fs;
    logic [7:0]       exp_sync;
    logic [3:0][31:0] exp_addr;
  } frame_vec_t;

  frame_vec_t   vecs [3];
  int           vec_cnt  = 0;
  int           err_cnt  = 0;
  int           buffered = 0;
  int           burst_cnt = 0;
  int           beat_seq = 0;
  logic [31:0]  addr_q [$];
  logic [127:0] exp_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // FDMA read-channel model: accepts a request, raises busy, streams rsize beats.
  initial begin
    rbusy  = 1'b0;
    rvalid = 1'b0;
    rdata  = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && rareq && !rbusy) begin
        check("free_at_req", (16 - buffered) >= 4, 1'b1);
        addr_q.push_back(raddr);
        burst_cnt++;
        rbusy = 1'b1;
        for (int i = 0; i < int'(rsize); i++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) break;
          rvalid = 1'b1;
          rdata  = {64'hFEED_FACE_0123_4567, 32'(burst_cnt), 32'(beat_seq)};
          exp_q.push_back(rdata);
          buffered++;
          beat_seq++;
        end
        @(negedge clk);
        rvalid = 1'b0;
        rbusy  = 1'b0;
      end
      if (rst_n !== 1'b1) begin
        rvalid = 1'b0;
        rbusy  = 1'b0;
      end
    end
  end

  // Stream sink: every beat popped must be the next one the model delivered.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && r_valid && r_ready) begin
        if (exp_q.size() == 0) check("unexpected_beat", r_valid, 1'b0);
        else begin
          check("beat_data", r_data, exp_q.pop_front());
          buffered--;
        end
      end
    end
  end

  task automatic pulse_fs();
    @(posedge clk); #2 fs = 1'b1;
    repeat (3) @(posedge clk);
    #2 fs = 1'b0;
  endtask

  task automatic run_frame(input frame_vec_t v);
    int cnt;
    int start_bursts;
    addr_q.delete();
    start_bursts = burst_cnt;
    @(posedge clk); #2 rbuf_sel = v.buf_sel; r_ready = v.ready;
    pulse_fs();
    if (v.mid_fs) begin
      cnt = 0;
      while (burst_cnt < start_bursts + 2 && cnt < 1000) begin @(negedge clk); cnt++; end
      check("mid_frame_reached", burst_cnt >= start_bursts + 2, 1'b1);
      pulse_fs();
    end
    cnt = 0;
    while (rirq !== 1'b1 && cnt < 3000) begin @(negedge clk); cnt++; end
    check("frame_done", rirq, 1'b1);
    check("done_buf", done_buf, v.buf_sel);
    check("sync_cnt", sync_cnt, v.exp_sync);
    cnt = 0;
    while (rirq === 1'b1 && cnt < 200) begin cnt++; @(negedge clk); end
    check("irq_len", cnt, 60);
    if (!v.ready) begin
      check("held_valid", r_valid, 1'b1);
      check("held_beats", buffered, 16);
      @(posedge clk); #2 r_ready = 1'b1;
      cnt = 0;
      while (r_valid === 1'b1 && cnt < 100) begin @(negedge clk); cnt++; end
    end
    repeat (4) @(negedge clk);
    check("beats_left", exp_q.size(), 0);
    check("valid_drained", r_valid, 1'b0);
    check("burst_count", addr_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < addr_q.size()) check("raddr", addr_q[i], v.exp_addr[i]);
    end
    if (v.mid_fs) begin
      cnt = burst_cnt;
      repeat (80) @(negedge clk);
      check("no_restart", burst_cnt, cnt);
      check("sync_hold", sync_cnt, v.exp_sync);
    end
  endtask

  initial begin
    int cnt;
    rst_n    = 1'b0;
    fs       = 1'b0;
    rbuf_sel = '0;
    r_ready  = 1'b0;

    vecs[0] = '{buf_sel: 8'd1, ready: 1'b1, mid_fs: 1'b0, exp_sync: 8'd1,
                exp_addr: {32'h0100_0140, 32'h0100_0100, 32'h0100_0040, 32'h0100_0000}};
    vecs[1] = '{buf_sel: 8'd2, ready: 1'b0, mid_fs: 1'b0, exp_sync: 8'd2,
                exp_addr: {32'h0200_0140, 32'h0200_0100, 32'h0200_0040, 32'h0200_0000}};
    vecs[2] = '{buf_sel: 8'd0, ready: 1'b1, mid_fs: 1'b1, exp_sync: 8'd0,
                exp_addr: {32'h0000_0140, 32'h0000_0100, 32'h0000_0040, 32'h0000_0000}};

    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", r_valid, 1'b0);
    check("rst_data", r_data, '0);
    check("rst_rareq", rareq, 1'b0);
    check("rst_rirq", rirq, 1'b0);
    check("rst_sync", sync_cnt, 8'd0);
    check("rst_rbuf", done_buf, 8'd0);
    check("rst_raddr", raddr, 32'd0);
    check("rst_rready", rready, 1'b1);
    check("rst_rsize", rsize, 16'd4);
    rst_n = 1'b1;

    for (int f = 0; f < 3; f++) run_frame(vecs[f]);

    // Reset in the middle of a burst aborts everything at once.
    @(posedge clk); #2 rbuf_sel = 8'd1; r_ready = 1'b1;
    pulse_fs();
    cnt = 0;
    while (rbusy !== 1'b1 && cnt < 500) begin @(negedge clk); cnt++; end
    check("abort_busy_seen", rbusy, 1'b1);
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("abort_state", dut.state_q, S_IDLE);
    check("abort_valid", r_valid, 1'b0);
    check("abort_rareq", rareq, 1'b0);
    check("abort_rirq", rirq, 1'b0);
    check("abort_sync", sync_cnt, 8'd0);
    repeat (3) @(negedge clk);
    exp_q.delete();
    buffered = 0;
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_rareq", rareq, 1'b0);
    check("post_rst_valid", r_valid, 1'b0);
    check("post_rst_rsize", rsize, 16'd4);

`ifdef RDBUF_UNDERFLOW_CNT_EN
    @(posedge clk); #2 r_ready = 1'b0;
    pulse_fs();
    repeat (4) @(posedge clk);
    #2 r_ready = 1'b1;
    repeat (5) @(posedge clk);
    #2 r_ready = 1'b0;
    check("underflow", underflow, 16'd5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
